bht_table: RTL and testbench



---
 rtl/bht_table_if.sv | 32 +++
 rtl/bht_table.sv | 167 ++++++++++++++++
 tb/tb_bht_table.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bht_table_if.sv
// Update and lookup bus between the BPU scoreboard/fetch stage and the BHT.
// Latency: n/a (wires only); the lookup response trails rd_valid by one cycle.
// Backpressure: none; one update and one lookup may be offered every cycle.
interface bht_table_if #(
  parameter int INDEX_WIDTH = 9,
  parameter int PC_WIDTH    = 48
);
  logic                   bht_write_enable;
  logic [INDEX_WIDTH-1:0] bht_write_index;
  logic [1:0]             bht_write_counter_select;
  logic                   bht_write_inc;
  logic                   bht_write_dec;
  logic                   bht_valid_in;
  logic                   rd_valid;
  logic [PC_WIDTH-1:0]    rd_pc;
  logic                   rd_resp_valid;
  logic                   rd_set_valid;
  logic [7:0]             rd_counters;
  logic [3:0]             rd_taken;

  modport master (
    output bht_write_enable, bht_write_index, bht_write_counter_select,
           bht_write_inc, bht_write_dec, bht_valid_in, rd_valid, rd_pc,
    input  rd_resp_valid, rd_set_valid, rd_counters, rd_taken
  );

  modport slave (
    input  bht_write_enable, bht_write_index, bht_write_counter_select,
           bht_write_inc, bht_write_dec, bht_valid_in, rd_valid, rd_pc,
    output rd_resp_valid, rd_set_valid, rd_counters, rd_taken
  );
endinterface

// File: rtl/bht_table.sv
// Branch history table: 2^INDEX_WIDTH sets of four 2-bit saturating counters plus a set-valid bit.
// Latency: lookup response one cycle after rd_valid; updates visible from the next cycle (write-first bypass).
// Backpressure: none; updates are dropped only while the post-reset clear walk runs. Optional PMU: BHT_PMU_EN.
module bht_table #(
  parameter int         INDEX_WIDTH = 9,
  parameter int         PC_WIDTH    = 48,
  parameter logic [1:0] INIT_CNT    = 2'b01
) (
  input  logic        clock,
  input  logic        reset_n,
  bht_table_if.slave  bus,
  output logic        init_done
`ifdef BHT_PMU_EN
  ,
  output logic [31:0] pmu_upd_cnt,
  output logic [31:0] pmu_sat_hi_cnt,
  output logic [31:0] pmu_sat_lo_cnt
`endif
);

  localparam int         NUM_SETS = 1 << INDEX_WIDTH;
  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  typedef struct packed {
    logic            valid;
    logic [3:0][1:0] cnt;
  } bht_set_t;

  localparam bht_set_t INIT_SET = '{valid: 1'b0, cnt: {4{INIT_CNT}}};

  logic [0:0]             state_q, state_d;
  logic [INDEX_WIDTH-1:0] init_ptr_q, init_ptr_d;
  bht_set_t               set_q [NUM_SETS];

  logic                   upd_acc;
  bht_set_t               cur_set, upd_set, rd_set;
  logic [1:0]             cur_cnt, new_cnt;
  logic [INDEX_WIDTH-1:0] rd_idx;
  logic                   mem_we;
  logic [INDEX_WIDTH-1:0] mem_waddr;
  bht_set_t               mem_wdata;
  logic [3:0]             taken_d;

  logic                   resp_vld_q;
  logic                   set_vld_q;
  logic [7:0]             counters_q;
  logic [3:0]             taken_q;

  logic                   unused_pc_bits;
  assign unused_pc_bits = ^{bus.rd_pc[PC_WIDTH-1:INDEX_WIDTH+4], bus.rd_pc[3:0]};

  assign rd_idx    = bus.rd_pc[INDEX_WIDTH+3:4];
  assign upd_acc   = (state_q == ST_READY) && bus.bht_write_enable;
  assign init_done = (state_q == ST_READY);

  // Clear-walk sequencing: one set per cycle, then park in READY until reset.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    if (state_q == ST_INIT) begin
      init_ptr_d = init_ptr_q + 1'b1;
      if (init_ptr_q == {INDEX_WIDTH{1'b1}}) state_d = ST_READY;
    end
  end

  // FSM and clear pointer state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  // Saturating read-modify-write of the selected counter; the set-valid bit always takes bht_valid_in.
  always_comb begin
    cur_set = set_q[bus.bht_write_index];
    cur_cnt = cur_set.cnt[bus.bht_write_counter_select];
    new_cnt = cur_cnt;
    if (bus.bht_write_inc && !bus.bht_write_dec && cur_cnt != 2'd3)
      new_cnt = cur_cnt + 2'd1;
    else if (bus.bht_write_dec && !bus.bht_write_inc && cur_cnt != 2'd0)
      new_cnt = cur_cnt - 2'd1;
    upd_set                                  = cur_set;
    upd_set.valid                            = bus.bht_valid_in;
    upd_set.cnt[bus.bht_write_counter_select] = new_cnt;
  end

  // Single write port shared by the clear walk and accepted updates.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.bht_write_index;
    mem_wdata = upd_set;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_ptr_q;
      mem_wdata = INIT_SET;
    end else if (upd_acc) begin
      mem_we = 1'b1;
    end
  end

  // Table storage; contents are defined by the clear walk rather than by reset.
  always_ff @(posedge clock) begin
    if (mem_we) set_q[mem_waddr] <= mem_wdata;
  end

  // Lookup source: forced clear value during INIT, write-first bypass on a same-index update.
  always_comb begin
    if (state_q == ST_INIT)
      rd_set = INIT_SET;
    else if (upd_acc && bus.bht_write_index == rd_idx)
      rd_set = upd_set;
    else
      rd_set = set_q[rd_idx];
    for (int i = 0; i < 4; i++) taken_d[i] = rd_set.cnt[i][1] & rd_set.valid;
  end

  // Registered lookup response; data fields hold when no lookup is issued.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_vld_q <= 1'b0;
      set_vld_q  <= 1'b0;
      counters_q <= '0;
      taken_q    <= '0;
    end else begin
      resp_vld_q <= bus.rd_valid;
      if (bus.rd_valid) begin
        set_vld_q  <= rd_set.valid;
        counters_q <= rd_set.cnt;
        taken_q    <= taken_d;
      end
    end
  end

  assign bus.rd_resp_valid = resp_vld_q;
  assign bus.rd_set_valid  = set_vld_q;
  assign bus.rd_counters   = counters_q;
  assign bus.rd_taken      = taken_q;

`ifdef BHT_PMU_EN
  logic [31:0] upd_cnt_q, sat_hi_cnt_q, sat_lo_cnt_q;

  // Event counters: accepted updates and saturating inc/dec attempts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      upd_cnt_q    <= '0;
      sat_hi_cnt_q <= '0;
      sat_lo_cnt_q <= '0;
    end else if (upd_acc) begin
      upd_cnt_q <= upd_cnt_q + 32'd1;
      if (bus.bht_write_inc && !bus.bht_write_dec && cur_cnt == 2'd3)
        sat_hi_cnt_q <= sat_hi_cnt_q + 32'd1;
      if (bus.bht_write_dec && !bus.bht_write_inc && cur_cnt == 2'd0)
        sat_lo_cnt_q <= sat_lo_cnt_q + 32'd1;
    end
  end

  assign pmu_upd_cnt    = upd_cnt_q;
  assign pmu_sat_hi_cnt = sat_hi_cnt_q;
  assign pmu_sat_lo_cnt = sat_lo_cnt_q;
`endif

endmodule

// File: tb/tb_bht_table.sv
// Randomized and directed bench for bht_table against a set/counter array model.
// Latency: model predicts outputs one cycle after each applied input set.
// Backpressure: none exercised; the DUT accepts every cycle.
module tb_bht_table;
  localparam int         IW       = 9;
  localparam int         PW       = 48;
  localparam int         NS       = 1 << IW;
  localparam logic [1:0] INIT_CNT = 2'b01;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic init_done;
`ifdef BHT_PMU_EN
  logic [31:0] pmu_upd_cnt, pmu_sat_hi_cnt, pmu_sat_lo_cnt;
`endif

  always #5 clock = ~clock;

  bht_table_if #(.INDEX_WIDTH(IW), .PC_WIDTH(PW)) bus ();

  bht_table #(.INDEX_WIDTH(IW), .PC_WIDTH(PW), .INIT_CNT(INIT_CNT)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .init_done (init_done)
`ifdef BHT_PMU_EN
    ,
    .pmu_upd_cnt    (pmu_upd_cnt),
    .pmu_sat_hi_cnt (pmu_sat_hi_cnt),
    .pmu_sat_lo_cnt (pmu_sat_lo_cnt)
`endif
  );

  // Behavioural model: counters as plain integers 0..3, one valid flag per set.
  int mcnt [NS][4];
  bit mval [NS];
  int cyc;
  bit e_resp, e_sv;
  int e_cnt [4];
  int e_upd, e_sathi, e_satlo;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      for (int k = 0; k < 4; k++) mcnt[s][k] = int'(INIT_CNT);
      mval[s] = 1'b0;
    end
    cyc    = 0;
    e_resp = 1'b0;
    e_sv   = 1'b0;
    for (int k = 0; k < 4; k++) e_cnt[k] = 0;
    e_upd = 0; e_sathi = 0; e_satlo = 0;
  endtask

  // Predict the state after the coming clock edge from the inputs now on the bus.
  task automatic model_step();
    bit ready;
    int idx, sel, c;
    ready = (cyc >= NS);
    if (ready && bus.bht_write_enable) begin
      idx = int'(bus.bht_write_index);
      sel = int'(bus.bht_write_counter_select);
      c   = mcnt[idx][sel];
      e_upd++;
      if (bus.bht_write_inc && !bus.bht_write_dec) begin
        if (c == 3) e_sathi++;
        else mcnt[idx][sel] = c + 1;
      end else if (bus.bht_write_dec && !bus.bht_write_inc) begin
        if (c == 0) e_satlo++;
        else mcnt[idx][sel] = c - 1;
      end
      mval[idx] = bus.bht_valid_in;
    end
    e_resp = bus.rd_valid;
    if (bus.rd_valid) begin
      if (!ready) begin
        e_sv = 1'b0;
        for (int k = 0; k < 4; k++) e_cnt[k] = int'(INIT_CNT);
      end else begin
        idx  = int'(bus.rd_pc[IW+3:4]);
        e_sv = mval[idx];
        for (int k = 0; k < 4; k++) e_cnt[k] = mcnt[idx][k];
      end
    end
    cyc++;
  endtask

  task automatic check_outputs();
    logic [7:0] exp_c;
    logic [3:0] exp_t;
    for (int k = 0; k < 4; k++) begin
      exp_c[2*k +: 2] = 2'(e_cnt[k]);
      exp_t[k]        = (e_cnt[k] >= 2) && e_sv;
    end
    check("init_done",     init_done,         (cyc >= NS));
    check("rd_resp_valid", bus.rd_resp_valid, e_resp);
    check("rd_set_valid",  bus.rd_set_valid,  e_sv);
    check("rd_counters",   bus.rd_counters,   exp_c);
    check("rd_taken",      bus.rd_taken,      exp_t);
`ifdef BHT_PMU_EN
    check("pmu_upd_cnt",    pmu_upd_cnt,    e_upd);
    check("pmu_sat_hi_cnt", pmu_sat_hi_cnt, e_sathi);
    check("pmu_sat_lo_cnt", pmu_sat_lo_cnt, e_satlo);
`endif
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic drive(input bit we, input int idx, input int sel, input bit inc, input bit dec,
                       input bit vin, input bit rv, input logic [PW-1:0] pc);
    bus.bht_write_enable         = we;
    bus.bht_write_index          = IW'(idx);
    bus.bht_write_counter_select = 2'(sel);
    bus.bht_write_inc            = inc;
    bus.bht_write_dec            = dec;
    bus.bht_valid_in             = vin;
    bus.rd_valid                 = rv;
    bus.rd_pc                    = pc;
    cycle();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  task automatic reset_dut(input int hold);
    @(negedge clock);
    bus.bht_write_enable = 1'b0;
    bus.rd_valid         = 1'b0;
    reset_n              = 1'b0;
    model_reset();
    #1;
    check("reset init_done",     init_done,         1'b0);
    check("reset rd_resp_valid", bus.rd_resp_valid, 1'b0);
    check("reset rd_set_valid",  bus.rd_set_valid,  1'b0);
    check("reset rd_counters",   bus.rd_counters,   8'h00);
    check("reset rd_taken",      bus.rd_taken,      4'h0);
    repeat (hold) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic lookup_lit(input string name, input logic [PW-1:0] pc,
                            input logic [7:0] cnt, input logic sv, input logic [3:0] tk);
    drive(0, 0, 0, 0, 0, 0, 1, pc);
    check({name, " resp"},     bus.rd_resp_valid, 1'b1);
    check({name, " counters"}, bus.rd_counters,   cnt);
    check({name, " set_valid"}, bus.rd_set_valid, sv);
    check({name, " taken"},    bus.rd_taken,      tk);
  endtask

  task automatic run_to_ready(input string name);
    while (cyc < NS - 1) idle();
    check({name, " init_done at 511"}, init_done, 1'b0);
    idle();
    check({name, " init_done at 512"}, init_done, 1'b1);
  endtask

  initial begin
    logic [63:0]   r;
    logic [PW-1:0] pc;
    int            widx, ridx;

    bus.bht_write_enable = 1'b0; bus.bht_write_index = '0; bus.bht_write_counter_select = '0;
    bus.bht_write_inc = 1'b0; bus.bht_write_dec = 1'b0; bus.bht_valid_in = 1'b0;
    bus.rd_valid = 1'b0; bus.rd_pc = '0;

    reset_dut(3);

    // INIT phase: a dropped update and a lookup answered with the clear value.
    drive(1, 'h10, 0, 1, 0, 1, 0, '0);
    lookup_lit("init lookup", 48'h1230, 8'h55, 1'b0, 4'b0000);
    run_to_ready("first init");

    // Three increments on slot 2 of set 0x23 saturate it at 3.
    repeat (3) drive(1, 'h23, 2, 1, 0, 1, 0, '0);
    lookup_lit("inc x3", 48'h230, 8'h75, 1'b1, 4'b0100);

    // Saturation at both ends on slot 1 of set 0x30.
    repeat (5) drive(1, 'h30, 1, 1, 0, 1, 0, '0);
    lookup_lit("sat hi", 48'h300, 8'h5D, 1'b1, 4'b0010);
    repeat (4) drive(1, 'h30, 1, 0, 1, 1, 0, '0);
    lookup_lit("dec x4", 48'h300, 8'h51, 1'b1, 4'b0000);
    drive(1, 'h30, 1, 0, 1, 1, 0, '0);
    lookup_lit("sat lo", 48'h300, 8'h51, 1'b1, 4'b0000);

    // Same-cycle write and lookup: same set bypasses, different set is untouched.
    drive(1, 'h40, 0, 1, 0, 1, 1, 48'h400);
    check("bypass counters",  bus.rd_counters,  8'h56);
    check("bypass set_valid", bus.rd_set_valid, 1'b1);
    drive(1, 'h41, 0, 1, 0, 1, 1, 48'h420);
    check("no-alias counters",  bus.rd_counters,  8'h55);
    check("no-alias set_valid", bus.rd_set_valid, 1'b0);

    // inc and dec together: counter holds, valid bit still written.
    drive(1, 'h50, 3, 1, 1, 1, 0, '0);
    lookup_lit("inc+dec", 48'h500, 8'h55, 1'b1, 4'b0000);

    // The update issued during INIT left no trace.
    lookup_lit("init write dropped", 48'h100, 8'h55, 1'b0, 4'b0000);

    // Random traffic over a small cluster of sets to provoke collisions and saturation.
    for (int n = 0; n < 3000; n++) begin
      widx = 'h80 + $urandom_range(0, 7);
      ridx = 'h80 + $urandom_range(0, 7);
      r    = {$urandom(), $urandom()};
      pc   = r[PW-1:0];
      pc[IW+3:4] = IW'(ridx);
      drive($urandom_range(0, 3) != 0, widx, $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, pc);
    end

    // Reset in the middle of READY, then again at init_ptr=300: full clear sequence repeats.
    reset_dut(2);
    repeat (300) idle();
    check("mid-init init_done", init_done, 1'b0);
    reset_dut(2);
    run_to_ready("re-init");
    lookup_lit("cleared 0x23", 48'h230, 8'h55, 1'b0, 4'b0000);
    lookup_lit("cleared 0x80", 48'h800, 8'h55, 1'b0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
